score_digit_encoder: RTL and testbench



---
 rtl/score_digit_encoder.sv | 126 ++++++++++++
 tb/tb_score_digit_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_digit_encoder.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding per-digit 7-segment encoders.
// Digit codes are 0-9, or 5'h10 for blank; overflow saturates all presented digits to 9.
module score_digit_encoder #(
    parameter int BIN_WIDTH  = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    blank_zeros,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [NUM_DIGITS*5-1:0] digits
);

    // Decimal digits needed for the largest BIN_WIDTH-bit value.
    function automatic int bcd_digit_count(input int width);
        longint max_val;
        int     n;
        max_val = (longint'(1) << width) - 1;
        n = 0;
        do begin
            n++;
            max_val = max_val / 10;
        end while (max_val > 0);
        return n;
    endfunction

    localparam int BCD_DIGITS = bcd_digit_count(BIN_WIDTH);
    localparam int DD_W       = 4 * BCD_DIGITS + BIN_WIDTH;
    localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int EXT_W      = 4 * EXT_DIGITS;
    localparam int CNT_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state;
    logic [DD_W-1:0]         dd;
    logic [DD_W-1:0]         dd_adj;
    logic [CNT_W-1:0]        count;
    logic                    blank_r;
    logic [EXT_W-1:0]        bcd_ext;
    logic                    ovf_c;
    logic [NUM_DIGITS*5-1:0] digits_c;
    logic                    leading;
    logic [3:0]              nib;

    // The BCD accumulator sits above the binary shift register so one left shift moves both.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        dd_adj = dd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (dd[BIN_WIDTH+4*i +: 4] >= 4'd5)
                dd_adj[BIN_WIDTH+4*i +: 4] = dd[BIN_WIDTH+4*i +: 4] + 4'd3;
        end
    end

    assign bcd_ext = EXT_W'(dd[DD_W-1:BIN_WIDTH]);

    always_comb begin
        ovf_c = 1'b0;
        for (int i = NUM_DIGITS; i < EXT_DIGITS; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0)
                ovf_c = 1'b1;
        end
        digits_c = '0;
        leading  = 1'b1;
        nib      = '0;
        // Walk from the most significant digit down; digit 0 always shows.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = bcd_ext[4*i +: 4];
            if (ovf_c)
                digits_c[5*i +: 5] = 5'd9;
            else if (blank_r && leading && nib == 4'd0 && i != 0)
                digits_c[5*i +: 5] = 5'h10;
            else
                digits_c[5*i +: 5] = {1'b0, nib};
            if (nib != 4'd0)
                leading = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            digits   <= {NUM_DIGITS{5'h10}};
            dd       <= '0;
            count    <= '0;
            blank_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dd      <= DD_W'(value);
                        blank_r <= blank_zeros;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    dd    <= dd_adj << 1;
                    count <= count + 1'b1;
                    if (count == CNT_W'(BIN_WIDTH - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    digits   <= digits_c;
                    overflow <= ovf_c;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_digit_encoder.sv
// Scoreboard bench: a 5-digit and a 4-digit instance share stimulus; expected digits come
// from decimal arithmetic on the applied value.
module tb_score_digit_encoder;

    localparam int LAT = 17;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic        blank_zeros;
    logic        busy, done, overflow;
    logic [24:0] digits;
    logic        busy4, done4, overflow4;
    logic [19:0] digits4;

    typedef struct {
        int unsigned acc;
        logic [24:0] d5;
        logic        o5;
        logic [19:0] d4;
        logic        o4;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc    = 0;
    int          n_vec  = 0;
    int          n_bad  = 0;
    int          run    = 0;
    logic [24:0] shown5 = {5{5'h10}};
    logic        shown_o5 = 1'b0;
    logic [19:0] shown4 = {4{5'h10}};
    logic        shown_o4 = 1'b0;

    score_digit_encoder #(.BIN_WIDTH(16), .NUM_DIGITS(5)) dut (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .blank_zeros(blank_zeros), .busy(busy), .done(done),
        .overflow(overflow), .digits(digits)
    );

    score_digit_encoder #(.BIN_WIDTH(16), .NUM_DIGITS(4)) dut4 (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .blank_zeros(blank_zeros), .busy(busy4), .done(done4),
        .overflow(overflow4), .digits(digits4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic int unsigned pow10(input int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic void model(input int unsigned v, input bit bz, input int nd,
                                  output logic [29:0] d, output logic ovf);
        d   = '0;
        ovf = (v >= pow10(nd));
        for (int i = 0; i < nd; i++) begin
            if (ovf)
                d[5*i +: 5] = 5'd9;
            else if (bz && i > 0 && v < pow10(i))
                d[5*i +: 5] = 5'h10;
            else
                d[5*i +: 5] = 5'((v / pow10(i)) % 10);
        end
    endfunction

    // Called on a falling edge; the conversion is accepted on the next rising edge.
    task automatic convert(input int unsigned v, input bit bz);
        exp_t        e;
        logic [29:0] d;
        logic        o;
        start       = 1'b1;
        value       = 16'(v);
        blank_zeros = bz;
        e.acc = cyc + 1;
        model(v, bz, 5, d, o);
        e.d5 = d[24:0];
        e.o5 = o;
        model(v, bz, 4, d, o);
        e.d4 = d[19:0];
        e.o4 = o;
        q.push_back(e);
        @(negedge clock);
        start       = 1'b0;
        value       = 16'($urandom);
        blank_zeros = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL idle_timeout at cycle %0d: busy still high", cyc);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout at cycle %0d: no done pulse", cyc);
        end
    endtask

    // Monitor: samples just after each rising edge.
    always begin
        @(posedge clock);
        cyc++;
        #1;
        if (reset) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ovf", overflow, 0);
            check("rst_digits", digits, {5{5'h10}});
            check("rst_digits4", digits4, {4{5'h10}});
            q.delete();
            shown5   = {5{5'h10}};
            shown_o5 = 1'b0;
            shown4   = {4{5'h10}};
            shown_o4 = 1'b0;
            run = 0;
        end else begin
            check("done_pair", done4, done);
            if (done) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done at cycle %0d: digits %0h", cyc, digits);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", cyc, e.acc + LAT);
                    check("digits", digits, e.d5);
                    check("overflow", overflow, e.o5);
                    check("digits4", digits4, e.d4);
                    check("overflow4", overflow4, e.o4);
                    shown5   = e.d5;
                    shown_o5 = e.o5;
                    shown4   = e.d4;
                    shown_o4 = e.o4;
                end
                check("busy_cycles", run, LAT);
                check("busy_in_done", busy, 0);
                run = 0;
            end else begin
                check("hold_digits", digits, shown5);
                check("hold_ovf", overflow, shown_o5);
                check("hold_digits4", digits4, shown4);
                check("hold_ovf4", overflow4, shown_o4);
                if (q.size() > 0 && cyc > q[0].acc + LAT) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL missing_done at cycle %0d: accepted at %0d", cyc, q[0].acc);
                    void'(q.pop_front());
                end
                if (busy) run++;
                else run = 0;
            end
        end
    end

    initial begin
        int unsigned v;
        reset       = 1'b1;
        start       = 1'b0;
        value       = '0;
        blank_zeros = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        convert(1234, 1'b0);  wait_idle();
        convert(0, 1'b1);     wait_idle();
        convert(65535, 1'b1); wait_idle();

        // Starts during a conversion are ignored; a start in the done cycle is taken.
        convert(305, 1'b0);
        @(negedge clock);
        start = 1'b1; value = 16'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        start = 1'b1; value = 16'd7;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        convert(42, 1'b0);    wait_idle();

        convert(12345, 1'b0); wait_idle();
        convert(9999, 1'b0);  wait_idle();

        // Reset mid-conversion, with a simultaneous start that must lose.
        convert(1000, 1'b1);
        repeat (6) @(negedge clock);
        reset = 1'b1; start = 1'b1; value = 16'd77;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        check("busy_after_reset", busy, 0);
        convert(50, 1'b1);    wait_idle();

        repeat (40) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, 65535);
            endcase
            convert(v, 1'($urandom_range(0, 1)));
            wait_idle();
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
